shot_seq: RTL and testbench

//  Multi-shot sequencer sitting directly upstream of the proc_core array in dsp.
//  On a start strobe it runs nshot shots. Each shot pulses proc_reset to the cores,

---
 rtl/shot_seq.sv | 272 +++++++++++++++++++++++++++
 tb/tb_shot_seq.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_seq.sv
// ---------------------------------------------------------------------------
// shot_seq -- multi-shot sequencer for the proc_core array
//
// A start strobe launches a sequence of nshot shots. Every shot holds
// proc_reset high for RST_CYCLES cycles. It then waits until every enabled
// core has raised its procend strobe, and then idles shot_delay cycles
// before the next shot begins. A per-shot watchdog ends the sequence early
// if the cores stall.
//
// Ports
//   clk           system clock
//   resetn        asynchronous active-low reset
//   stb_start     1-cycle start request, only honoured in IDLE
//   stb_abort     1-cycle abort, returns to IDLE from any other state
//   nshot         number of shots to run (latched on start)
//   shot_delay    idle cycles between shots (latched on start)
//   proc_mask     per-core participation mask (latched on start)
//   tout_limit    max RUN cycles per shot, 0 = no watchdog (latched on start)
//   procend       per-core done strobe, pulse or level
//   proc_reset    reset to the cores, high during each shot's reset phase
//   busy          high from accepted start until the DONE state is left
//   shotcnt       0-based index of the current shot
//   stb_shotdone  1-cycle pulse per completed shot
//   lastshotdone  sticky, set when the sequence ends, cleared on next start
//   timeout       sticky, set on watchdog expiry, cleared on next start
// ---------------------------------------------------------------------------
module shot_seq #(
    parameter int NPROC       = 4,
    parameter int NSHOT_WIDTH = 32,
    parameter int DELAY_WIDTH = 24,
    parameter int RST_CYCLES  = 2,
    parameter int TOUT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   stb_start,
    input  logic                   stb_abort,
    input  logic [NSHOT_WIDTH-1:0] nshot,
    input  logic [DELAY_WIDTH-1:0] shot_delay,
    input  logic [NPROC-1:0]       proc_mask,
    input  logic [TOUT_WIDTH-1:0]  tout_limit,
    input  logic [NPROC-1:0]       procend,
    output logic                   proc_reset,
    output logic                   busy,
    output logic [NSHOT_WIDTH-1:0] shotcnt,
    output logic                   stb_shotdone,
    output logic                   lastshotdone,
    output logic                   timeout
);

    // Reset-phase counter only needs to reach RST_CYCLES-1.
    localparam int RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_RUN  = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 state_reg,        state_next;

    // Configuration captured on an accepted start.
    logic [NSHOT_WIDTH-1:0] nshot_reg,        nshot_next;
    logic [DELAY_WIDTH-1:0] delay_reg,        delay_next;
    logic [NPROC-1:0]       mask_reg,         mask_next;
    logic [TOUT_WIDTH-1:0]  tout_reg,         tout_next;

    // Sequencing state.
    logic [NSHOT_WIDTH-1:0] shotcnt_reg,      shotcnt_next;
    logic [NPROC-1:0]       done_seen_reg,    done_seen_next;
    logic [RST_CNT_W-1:0]   rst_cnt_reg,      rst_cnt_next;
    logic [DELAY_WIDTH-1:0] gap_cnt_reg,      gap_cnt_next;
    logic [TOUT_WIDTH-1:0]  wd_cnt_reg,       wd_cnt_next;

    // Registered outputs.
    logic                   proc_reset_reg,   proc_reset_next;
    logic                   busy_reg,         busy_next;
    logic                   shotdone_reg,     shotdone_next;
    logic                   lastshotdone_reg, lastshotdone_next;
    logic                   timeout_reg,      timeout_next;

    // -----------------------------------------------------------------------
    // Shot completion detect. A core is satisfied when it is masked off, has
    // already reported in this shot, or is reporting right now. Including the
    // live procend lets a pulse that lands on the deciding cycle count.
    // -----------------------------------------------------------------------
    logic [NPROC-1:0] core_ok;
    logic             all_done;
    logic             last_shot;
    logic             wd_expire;

    for (genvar gi = 0; gi < NPROC; gi++) begin : g_core
        assign core_ok[gi] = done_seen_reg[gi] | procend[gi] | ~mask_reg[gi];
    end

    assign all_done  = &core_ok;
    // nshot_reg is non-zero whenever RUN is reachable, so this never underflows.
    assign last_shot = (shotcnt_reg == (nshot_reg - NSHOT_WIDTH'(1)));
    // wd_cnt_reg holds the number of completed RUN cycles; expiry fires on the
    // cycle that would make it equal tout_limit.
    assign wd_expire = (tout_reg != '0) && (wd_cnt_reg == (tout_reg - TOUT_WIDTH'(1)));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= S_IDLE;
            nshot_reg        <= '0;
            delay_reg        <= '0;
            mask_reg         <= '0;
            tout_reg         <= '0;
            shotcnt_reg      <= '0;
            done_seen_reg    <= '0;
            rst_cnt_reg      <= '0;
            gap_cnt_reg      <= '0;
            wd_cnt_reg       <= '0;
            proc_reset_reg   <= 1'b0;
            busy_reg         <= 1'b0;
            shotdone_reg     <= 1'b0;
            lastshotdone_reg <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            nshot_reg        <= nshot_next;
            delay_reg        <= delay_next;
            mask_reg         <= mask_next;
            tout_reg         <= tout_next;
            shotcnt_reg      <= shotcnt_next;
            done_seen_reg    <= done_seen_next;
            rst_cnt_reg      <= rst_cnt_next;
            gap_cnt_reg      <= gap_cnt_next;
            wd_cnt_reg       <= wd_cnt_next;
            proc_reset_reg   <= proc_reset_next;
            busy_reg         <= busy_next;
            shotdone_reg     <= shotdone_next;
            lastshotdone_reg <= lastshotdone_next;
            timeout_reg      <= timeout_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        nshot_next        = nshot_reg;
        delay_next        = delay_reg;
        mask_next         = mask_reg;
        tout_next         = tout_reg;
        shotcnt_next      = shotcnt_reg;
        done_seen_next    = done_seen_reg;
        rst_cnt_next      = rst_cnt_reg;
        gap_cnt_next      = gap_cnt_reg;
        wd_cnt_next       = wd_cnt_reg;
        proc_reset_next   = proc_reset_reg;
        busy_next         = busy_reg;
        shotdone_next     = 1'b0;          // strobe: high for one cycle only
        lastshotdone_next = lastshotdone_reg;
        timeout_next      = timeout_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (stb_start) begin
                    nshot_next        = nshot;
                    delay_next        = shot_delay;
                    mask_next         = proc_mask;
                    tout_next         = tout_limit;
                    shotcnt_next      = '0;
                    done_seen_next    = '0;
                    lastshotdone_next = 1'b0;
                    timeout_next      = 1'b0;
                    busy_next         = 1'b1;
                    if (nshot == '0) begin
                        // Empty sequence: straight to DONE, cores untouched.
                        state_next        = S_DONE;
                        lastshotdone_next = 1'b1;
                    end else begin
                        state_next      = S_RST;
                        proc_reset_next = 1'b1;
                        rst_cnt_next    = '0;
                    end
                end
            end

            S_RST: begin
                // procend is meaningless while the cores are held in reset.
                done_seen_next = '0;
                if (rst_cnt_reg == RST_LAST) begin
                    state_next      = S_RUN;
                    proc_reset_next = 1'b0;
                    wd_cnt_next     = '0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + RST_CNT_W'(1);
                end
            end

            S_RUN: begin
                done_seen_next = done_seen_reg | procend;
                wd_cnt_next    = wd_cnt_reg + TOUT_WIDTH'(1);
                if (all_done) begin
                    shotdone_next = 1'b1;
                    if (last_shot) begin
                        state_next        = S_DONE;
                        lastshotdone_next = 1'b1;
                    end else if (delay_reg == '0) begin
                        // No gap: the next shot's reset starts right away.
                        state_next      = S_RST;
                        shotcnt_next    = shotcnt_reg + NSHOT_WIDTH'(1);
                        proc_reset_next = 1'b1;
                        rst_cnt_next    = '0;
                    end else begin
                        state_next   = S_GAP;
                        gap_cnt_next = '0;
                    end
                end else if (wd_expire) begin
                    // Completion wins over the watchdog on the same cycle.
                    state_next        = S_DONE;
                    timeout_next      = 1'b1;
                    lastshotdone_next = 1'b1;
                end
            end

            S_GAP: begin
                // Only reachable with delay_reg != 0, so delay_reg-1 is safe.
                if (gap_cnt_reg == (delay_reg - DELAY_WIDTH'(1))) begin
                    state_next      = S_RST;
                    shotcnt_next    = shotcnt_reg + NSHOT_WIDTH'(1);
                    proc_reset_next = 1'b1;
                    rst_cnt_next    = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + DELAY_WIDTH'(1);
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end

            default: begin
                state_next      = S_IDLE;
                proc_reset_next = 1'b0;
                busy_next       = 1'b0;
            end
        endcase

        // Abort overrides everything decided above, including a shot that
        // completes or a watchdog that fires in the same cycle. The shot
        // index and sticky flags are left as they were.
        if (stb_abort && (state_reg != S_IDLE)) begin
            state_next        = S_IDLE;
            proc_reset_next   = 1'b0;
            busy_next         = 1'b0;
            shotdone_next     = 1'b0;
            shotcnt_next      = shotcnt_reg;
            lastshotdone_next = lastshotdone_reg;
            timeout_next      = timeout_reg;
        end
    end

    assign proc_reset   = proc_reset_reg;
    assign busy         = busy_reg;
    assign shotcnt      = shotcnt_reg;
    assign stb_shotdone = shotdone_reg;
    assign lastshotdone = lastshotdone_reg;
    assign timeout      = timeout_reg;

endmodule

// File: tb/tb_shot_seq.sv
// ---------------------------------------------------------------------------
// tb_shot_seq -- directed self-checking bench for shot_seq.
// Time base: every "step" is one rising clock edge plus 1 time unit, so
// registered outputs of that edge are visible and inputs driven there are
// sampled by the following edge. Step k counts edges after the start strobe
// was driven (the strobe is sampled at step 1's edge).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shot_seq;

    localparam int NPROC = 4;
    localparam int NSW   = 32;
    localparam int DW    = 24;
    localparam int TW    = 32;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            stb_start = 1'b0;
    logic            stb_abort = 1'b0;
    logic [NSW-1:0]  nshot = '0;
    logic [DW-1:0]   shot_delay = '0;
    logic [NPROC-1:0] proc_mask = '0;
    logic [TW-1:0]   tout_limit = '0;
    logic [NPROC-1:0] procend = '0;
    logic            proc_reset;
    logic            busy;
    logic [NSW-1:0]  shotcnt;
    logic            stb_shotdone;
    logic            lastshotdone;
    logic            timeout;

    int tests_run = 0;
    int tests_failed = 0;

    shot_seq #(
        .NPROC(NPROC), .NSHOT_WIDTH(NSW), .DELAY_WIDTH(DW),
        .RST_CYCLES(2), .TOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .resetn(resetn),
        .stb_start(stb_start), .stb_abort(stb_abort),
        .nshot(nshot), .shot_delay(shot_delay), .proc_mask(proc_mask),
        .tout_limit(tout_limit), .procend(procend),
        .proc_reset(proc_reset), .busy(busy), .shotcnt(shotcnt),
        .stb_shotdone(stb_shotdone), .lastshotdone(lastshotdone),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int ns, input int dl, input logic [3:0] mk, input int tl);
        nshot      = NSW'(ns);
        shot_delay = DW'(dl);
        proc_mask  = mk;
        tout_limit = TW'(tl);
        stb_start  = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        logic [5:0] outs;
        resetn = 1'b0;
        step(); step();
        outs = {proc_reset, busy, stb_shotdone, lastshotdone, timeout, |shotcnt};
        tests_run++;
        if (outs !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_hold outputs=%b required=000000", outs);
        end
        resetn = 1'b1;
        step(); step();
        outs = {proc_reset, busy, stb_shotdone, lastshotdone, timeout, |shotcnt};
        tests_run++;
        if (outs !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_release outputs=%b required=000000", outs);
        end
        $display("[TB] reset: outputs after release %b", outs);
    endtask

    // ---------------------------------------------------------------------
    // 3 shots, no gap, all cores end 10 cycles after proc_reset falls.
    task automatic test_three_shots();
        int sd_n, pr_hi, bursts, cd, last_step, busy_fall;
        int sd_step[3];
        logic [NSW-1:0] burst_cnt[3];
        logic pr_prev, busy1;
        int exp_sd[3];
        exp_sd = '{14, 27, 40};
        sd_n = 0; pr_hi = 0; bursts = 0; cd = 0; last_step = 0; busy_fall = 0;
        pr_prev = 1'b0; busy1 = 1'b0;
        for (int i = 0; i < 3; i++) begin sd_step[i] = 0; burst_cnt[i] = '1; end
        setup(3, 0, 4'hF, 0);
        for (int k = 1; k <= 45; k++) begin
            step();
            stb_start = 1'b0;
            if (k == 1) busy1 = busy;
            if (stb_shotdone) begin
                if (sd_n < 3) sd_step[sd_n] = k;
                sd_n++;
            end
            if (proc_reset) pr_hi++;
            if (proc_reset && !pr_prev) begin
                if (bursts < 3) burst_cnt[bursts] = shotcnt;
                bursts++;
            end
            if (lastshotdone && last_step == 0) last_step = k;
            if (!busy && busy_fall == 0 && k > 1) busy_fall = k;
            procend = '0;
            if (!proc_reset && pr_prev) cd = 10;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) procend = 4'hF;
            end
            pr_prev = proc_reset;
        end
        tests_run++;
        if (busy1 !== 1'b1) begin tests_failed++; $display("FAIL t1_busy_on busy=%b required=1", busy1); end
        tests_run++;
        if (sd_n !== 3) begin tests_failed++; $display("FAIL t1_shotdone_count got=%0d required=3", sd_n); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (sd_step[i] !== exp_sd[i]) begin
                tests_failed++;
                $display("FAIL t1_shotdone_step[%0d] got=%0d required=%0d", i, sd_step[i], exp_sd[i]);
            end
            tests_run++;
            if (burst_cnt[i] !== NSW'(i)) begin
                tests_failed++;
                $display("FAIL t1_shotcnt_burst[%0d] got=%0d required=%0d", i, burst_cnt[i], i);
            end
        end
        tests_run++;
        if (pr_hi !== 6 || bursts !== 3) begin
            tests_failed++;
            $display("FAIL t1_proc_reset cycles=%0d bursts=%0d required=6/3", pr_hi, bursts);
        end
        tests_run++;
        if (last_step !== 40) begin tests_failed++; $display("FAIL t1_lastshotdone_step got=%0d required=40", last_step); end
        tests_run++;
        if (busy_fall !== 41) begin tests_failed++; $display("FAIL t1_busy_fall got=%0d required=41", busy_fall); end
        tests_run++;
        if (lastshotdone !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_final lastshotdone=%b busy=%b required=1/0", lastshotdone, busy);
        end
        $display("[TB] three_shots: shotdone at %0d %0d %0d, reset cycles %0d", sd_step[0], sd_step[1], sd_step[2], pr_hi);
    endtask

    // ---------------------------------------------------------------------
    // 2 shots, gap 5, cores finish on different cycles (pulses, then levels).
    task automatic test_gap_staggered();
        int sd_n, rise_n, last_step, busy_fall;
        int sd_step[2];
        int rise_step[2];
        logic [NSW-1:0] rise_cnt[2];
        logic pr_prev;
        sd_n = 0; rise_n = 0; last_step = 0; busy_fall = 0; pr_prev = 1'b0;
        for (int i = 0; i < 2; i++) begin sd_step[i] = 0; rise_step[i] = 0; rise_cnt[i] = '1; end
        setup(2, 5, 4'hF, 0);
        for (int k = 1; k <= 30; k++) begin
            step();
            stb_start = 1'b0;
            if (stb_shotdone) begin
                if (sd_n < 2) sd_step[sd_n] = k;
                sd_n++;
            end
            if (proc_reset && !pr_prev) begin
                if (rise_n < 2) begin rise_step[rise_n] = k; rise_cnt[rise_n] = shotcnt; end
                rise_n++;
            end
            if (lastshotdone && last_step == 0) last_step = k;
            if (!busy && busy_fall == 0 && k > 1) busy_fall = k;
            pr_prev = proc_reset;
            case (k)
                4:  procend = 4'b0001;
                6:  procend = 4'b0010;
                8:  procend = 4'b0100;
                10: procend = 4'b1000;
                19: procend = 4'b0001;
                20: procend = 4'b0011;
                21: procend = 4'b0111;
                22: procend = 4'b1111;
                default: procend = 4'b0000;
            endcase
        end
        tests_run++;
        if (sd_n !== 2 || sd_step[0] !== 11 || sd_step[1] !== 23) begin
            tests_failed++;
            $display("FAIL t2_shotdone count=%0d steps=%0d,%0d required=2 at 11,23", sd_n, sd_step[0], sd_step[1]);
        end
        tests_run++;
        if (rise_n !== 2 || rise_step[0] !== 1 || rise_step[1] !== 16) begin
            tests_failed++;
            $display("FAIL t2_proc_reset_rise count=%0d steps=%0d,%0d required=2 at 1,16", rise_n, rise_step[0], rise_step[1]);
        end
        tests_run++;
        if (rise_cnt[0] !== NSW'(0) || rise_cnt[1] !== NSW'(1)) begin
            tests_failed++;
            $display("FAIL t2_shotcnt got=%0d,%0d required=0,1", rise_cnt[0], rise_cnt[1]);
        end
        tests_run++;
        if (rise_step[1] - sd_step[0] !== 5) begin
            tests_failed++;
            $display("FAIL t2_gap_len got=%0d required=5", rise_step[1] - sd_step[0]);
        end
        tests_run++;
        if (last_step !== 23 || busy_fall !== 24) begin
            tests_failed++;
            $display("FAIL t2_end lastshotdone_step=%0d busy_fall=%0d required=23/24", last_step, busy_fall);
        end
        $display("[TB] gap_staggered: shotdone at %0d %0d, second reset at %0d", sd_step[0], sd_step[1], rise_step[1]);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_zero_shots();
        int pr_n, sd_n;
        logic b1, l1, b2;
        pr_n = 0; sd_n = 0; b1 = 0; l1 = 0; b2 = 1;
        setup(0, 0, 4'hF, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            stb_start = 1'b0;
            if (k == 1) begin b1 = busy; l1 = lastshotdone; end
            if (k == 2) b2 = busy;
            if (proc_reset) pr_n++;
            if (stb_shotdone) sd_n++;
        end
        tests_run++;
        if (b1 !== 1'b1 || l1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL t3_done_entry busy=%b lastshotdone=%b required=1/1", b1, l1);
        end
        tests_run++;
        if (b2 !== 1'b0) begin tests_failed++; $display("FAIL t3_busy_fall busy=%b required=0", b2); end
        tests_run++;
        if (pr_n !== 0 || sd_n !== 0) begin
            tests_failed++;
            $display("FAIL t3_no_activity proc_reset_cycles=%0d shotdone=%0d required=0/0", pr_n, sd_n);
        end
        $display("[TB] zero_shots: busy=%b lastshotdone=%b", b1, l1);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_mask_watchdog();
        int sd_step, to_step, sd_n, busy_fall;
        logic l1, to_seen;
        // Part A: core 1 masked off and silent -> completes without timeout.
        sd_step = 0; to_seen = 0; busy_fall = 0; l1 = 1;
        setup(1, 0, 4'b0101, 100);
        for (int k = 1; k <= 15; k++) begin
            step();
            stb_start = 1'b0;
            if (k == 1) l1 = lastshotdone;
            if (stb_shotdone && sd_step == 0) sd_step = k;
            if (timeout) to_seen = 1;
            if (!busy && busy_fall == 0 && k > 1) busy_fall = k;
            procend = (k == 10) ? 4'b0101 : 4'b0000;
        end
        tests_run++;
        if (l1 !== 1'b0) begin tests_failed++; $display("FAIL t4_lastshotdone_clear got=%b required=0", l1); end
        tests_run++;
        if (sd_step !== 11 || to_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4a_masked_done shotdone_step=%0d timeout_seen=%b required=11/0", sd_step, to_seen);
        end
        tests_run++;
        if (busy_fall !== 12 || lastshotdone !== 1'b1) begin
            tests_failed++;
            $display("FAIL t4a_end busy_fall=%0d lastshotdone=%b required=12/1", busy_fall, lastshotdone);
        end
        $display("[TB] mask_0101: shotdone at %0d", sd_step);

        // Part B: all cores required, core 1 never ends -> watchdog.
        to_step = 0; sd_n = 0; busy_fall = 0;
        setup(1, 0, 4'hF, 100);
        for (int k = 1; k <= 110; k++) begin
            step();
            stb_start = 1'b0;
            if (timeout && to_step == 0) to_step = k;
            if (stb_shotdone) sd_n++;
            if (!busy && busy_fall == 0 && k > 1) busy_fall = k;
            procend = (k == 10) ? 4'b0101 : 4'b0000;
        end
        tests_run++;
        if (to_step !== 103) begin tests_failed++; $display("FAIL t4b_timeout_step got=%0d required=103", to_step); end
        tests_run++;
        if (sd_n !== 0) begin tests_failed++; $display("FAIL t4b_no_shotdone got=%0d required=0", sd_n); end
        tests_run++;
        if (lastshotdone !== 1'b1 || timeout !== 1'b1 || busy_fall !== 104) begin
            tests_failed++;
            $display("FAIL t4b_end lastshotdone=%b timeout=%b busy_fall=%0d required=1/1/104", lastshotdone, timeout, busy_fall);
        end
        $display("[TB] watchdog: timeout at %0d", to_step);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_abort();
        int sd_n, sd_step;
        logic t1;
        logic [4:0] st11;
        logic [NSW-1:0] cnt11, cnt_r;
        logic b15, b1, p1, l4;
        sd_n = 0; t1 = 1; st11 = '1; cnt11 = '1; b15 = 1;
        setup(4, 0, 4'hF, 0);
        for (int k = 1; k <= 15; k++) begin
            step();
            stb_start = 1'b0;
            if (k == 1) t1 = timeout;
            if (stb_shotdone) sd_n++;
            if (k == 11) begin
                st11  = {busy, proc_reset, stb_shotdone, lastshotdone, timeout};
                cnt11 = shotcnt;
            end
            if (k == 15) b15 = busy;
            procend   = (k == 5 || k == 10) ? 4'hF : 4'h0;
            stb_abort = (k == 10);
        end
        tests_run++;
        if (t1 !== 1'b0) begin tests_failed++; $display("FAIL t5_timeout_clear got=%b required=0", t1); end
        tests_run++;
        if (sd_n !== 1) begin tests_failed++; $display("FAIL t5_shotdone_count got=%0d required=1", sd_n); end
        tests_run++;
        if (st11 !== 5'b0) begin
            tests_failed++;
            $display("FAIL t5_after_abort busy,proc_reset,shotdone,last,timeout=%b required=00000", st11);
        end
        tests_run++;
        if (cnt11 !== NSW'(1)) begin tests_failed++; $display("FAIL t5_shotcnt_held got=%0d required=1", cnt11); end
        tests_run++;
        if (b15 !== 1'b0) begin tests_failed++; $display("FAIL t5_stays_idle busy=%b required=0", b15); end
        $display("[TB] abort: shotcnt held at %0d", cnt11);

        // Restart with an empty mask: shot completes on first RUN cycle.
        sd_step = 0; b1 = 0; p1 = 0; cnt_r = '1; l4 = 0;
        setup(1, 0, 4'h0, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            stb_start = 1'b0;
            if (k == 1) begin b1 = busy; p1 = proc_reset; cnt_r = shotcnt; end
            if (stb_shotdone && sd_step == 0) sd_step = k;
            if (k == 4) l4 = lastshotdone;
        end
        tests_run++;
        if (cnt_r !== NSW'(0) || b1 !== 1'b1 || p1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL t5_restart shotcnt=%0d busy=%b proc_reset=%b required=0/1/1", cnt_r, b1, p1);
        end
        tests_run++;
        if (sd_step !== 4 || l4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL t5_mask0 shotdone_step=%0d lastshotdone=%b required=4/1", sd_step, l4);
        end
        $display("[TB] restart mask0: shotdone at %0d", sd_step);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_async_reset();
        logic [2:0] st10;
        logic [NSW-1:0] cnt10;
        logic [5:0] outs;
        st10 = '1; cnt10 = '1;
        setup(2, 0, 4'hF, 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            stb_start = 1'b0;
            if (k == 10) begin st10 = {busy, proc_reset, stb_shotdone}; cnt10 = shotcnt; end
            procend = (k == 5) ? 4'hF : 4'h0;
            if (k == 9) stb_start = 1'b1;   // ignored: sequence is busy
        end
        tests_run++;
        if (st10 !== 3'b100 || cnt10 !== NSW'(1)) begin
            tests_failed++;
            $display("FAIL t6_start_ignored busy,proc_reset,shotdone=%b shotcnt=%0d required=100/1", st10, cnt10);
        end
        #2;
        resetn = 1'b0;
        #1;
        outs = {proc_reset, busy, stb_shotdone, lastshotdone, timeout, |shotcnt};
        tests_run++;
        if (outs !== 6'b0) begin
            tests_failed++;
            $display("FAIL t6_async_reset outputs=%b required=000000", outs);
        end
        step();
        resetn = 1'b1;
        step(); step();
        outs = {proc_reset, busy, stb_shotdone, lastshotdone, timeout, |shotcnt};
        tests_run++;
        if (outs !== 6'b0) begin
            tests_failed++;
            $display("FAIL t6_after_release outputs=%b required=000000", outs);
        end
        $display("[TB] async_reset: outputs %b", outs);
    endtask

    initial begin
        test_reset();
        test_three_shots();
        test_gap_staggered();
        test_zero_shots();
        test_mask_watchdog();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
